alu_b_operand_stage: RTL and testbench

//  Selects the ALU operand B from register, forwarded results, PC increment, immediate or

---
 rtl/alu_b_operand_stage_pkg.sv | 25 ++
 rtl/alu_b_operand_stage_if.sv | 34 +++
 rtl/alu_b_operand_stage_skid_buffer.sv | 83 ++++++++
 rtl/alu_b_operand_stage.sv | 60 ++++++
 tb/tb_alu_b_operand_stage.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/alu_b_operand_stage_pkg.sv
// Shared types for the ALU operand-B stage: source and forwarding selectors
// plus the skid-buffer occupancy state.
package alu_src_pkg;

  typedef enum logic [1:0] {
    SRC_REG    = 2'd0,
    SRC_INC    = 2'd1,
    SRC_IMM    = 2'd2,
    SRC_IMM_SH = 2'd3
  } src_b_e;

  typedef enum logic [1:0] {
    FWD_NONE  = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2,
    FWD_RSVD  = 2'd3
  } fwd_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_e;

endpackage

// File: rtl/alu_b_operand_stage_if.sv
// Operand-B stage bus: upstream request (selectors and candidate values)
// and downstream valid/ready operand output.
interface alu_b_operand_stage_if #(
  parameter int unsigned DATA_W = 64
);
  import alu_src_pkg::*;

  logic              in_valid;
  logic              in_ready;
  src_b_e            src_sel;
  fwd_e              fwd_sel;
  logic [DATA_W-1:0] reg_b;
  logic [DATA_W-1:0] fwd_exmem;
  logic [DATA_W-1:0] fwd_memwb;
  logic [DATA_W-1:0] imm_sext;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  // Driver side: decode upstream plus the consuming ALU.
  modport master (
    output in_valid, src_sel, fwd_sel, reg_b, fwd_exmem, fwd_memwb, imm_sext,
    output out_ready,
    input  in_ready, out_valid, out_data
  );

  // Stage side.
  modport slave (
    input  in_valid, src_sel, fwd_sel, reg_b, fwd_exmem, fwd_memwb, imm_sext,
    input  out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/alu_b_operand_stage_skid_buffer.sv
// Two-entry skid buffer: M drives the output, S catches one extra operand
// so in_ready depends only on registered state.
module skid_buffer
  import alu_src_pkg::*;
#(
  parameter int unsigned W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_data_i,
  output logic         in_ready_o,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  stage_state_e state_q, state_d;
  logic [W-1:0] m_q, m_d;
  logic [W-1:0] s_q, s_d;
  logic         accept;
  logic         xfer;

  // Handshake outputs come straight from registered state.
  always_comb begin
    in_ready_o  = (state_q != ST_FULL);
    out_valid_o = (state_q != ST_EMPTY);
    out_data_o  = m_q;
    accept      = in_valid_i && in_ready_o;
    xfer        = out_valid_o && out_ready_i;
  end

  // Next occupancy and data movement; flush empties and freezes the data.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_ONE;
            m_d     = in_data_i;
          end
        end
        ST_ONE: begin
          if (accept && xfer) begin
            m_d = in_data_i;
          end else if (accept) begin
            state_d = ST_FULL;
            s_d     = in_data_i;
          end else if (xfer) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (xfer) begin
            state_d = ST_ONE;
            m_d     = s_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // State and storage registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      m_q     <= '0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      s_q     <= s_d;
    end
  end

endmodule

// File: rtl/alu_b_operand_stage.sv
// ALU operand-B stage: selects operand B from register/forwarding/PC
// increment/immediate sources and registers it through a skid buffer.
module alu_b_operand_stage
  import alu_src_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned PC_INC = 4,
  parameter int unsigned IMM_SH = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  alu_b_operand_stage_if.slave  bus
);

  localparam logic [DATA_W-1:0] INC_VAL = DATA_W'(PC_INC);

  logic [DATA_W-1:0] sel_data;

  // Operand-B source mux; reserved forwarding code falls back to the register value.
  always_comb begin
    sel_data = bus.reg_b;
    unique case (bus.src_sel)
      SRC_REG: begin
        unique case (bus.fwd_sel)
          FWD_EXMEM: sel_data = bus.fwd_exmem;
          FWD_MEMWB: sel_data = bus.fwd_memwb;
          default:   sel_data = bus.reg_b;
        endcase
      end
      SRC_INC:    sel_data = INC_VAL;
      SRC_IMM:    sel_data = bus.imm_sext;
      SRC_IMM_SH: sel_data = bus.imm_sext << IMM_SH;
      default:    sel_data = bus.reg_b;
    endcase
  end

  skid_buffer #(
    .W (DATA_W)
  ) u_skid (
    .clk         (clk),
    .rst         (reset),
    .flush_i     (flush),
    .in_valid_i  (bus.in_valid),
    .in_data_i   (sel_data),
    .in_ready_o  (bus.in_ready),
    .out_valid_o (bus.out_valid),
    .out_ready_i (bus.out_ready),
    .out_data_o  (bus.out_data)
  );

  // Flag use of the reserved forwarding code on an accepted register operand.
  always_ff @(posedge clk) begin
    if (!reset && bus.in_valid && bus.in_ready && bus.src_sel == SRC_REG) begin
      assert (bus.fwd_sel != FWD_RSVD)
        else $warning("alu_b_operand_stage: reserved fwd_sel code used, treated as NONE");
    end
  end

endmodule

// File: tb/tb_alu_b_operand_stage.sv
// Directed bench for alu_b_operand_stage with hand-computed expectations.
module tb_alu_b_operand_stage;
  import alu_src_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  int unsigned total = 0;
  int unsigned bad = 0;

  alu_b_operand_stage_if #(.DATA_W(64)) bus ();

  alu_b_operand_stage #(
    .DATA_W (64),
    .PC_INC (4),
    .IMM_SH (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input src_b_e s, input fwd_e f, input logic [63:0] imm);
    bus.in_valid = 1'b1;
    bus.src_sel  = s;
    bus.fwd_sel  = f;
    bus.imm_sext = imm;
  endtask

  initial begin
    reset         = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.src_sel   = SRC_REG;
    bus.fwd_sel   = FWD_NONE;
    bus.reg_b     = 64'd5;
    bus.fwd_exmem = 64'd7;
    bus.fwd_memwb = 64'd9;
    bus.imm_sext  = '0;
    bus.out_ready = 1'b0;
    tick();
    chk("rst_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_data",  bus.out_data, 64'd0);
    chk("rst_ready", {63'd0, bus.in_ready}, 64'd1);
    reset = 1'b0;
    tick();

    // PC increment constant
    bus.out_ready = 1'b1;
    req(SRC_INC, FWD_NONE, '0);
    tick();
    chk("inc_valid", {63'd0, bus.out_valid}, 64'd1);
    chk("inc_data",  bus.out_data, 64'd4);
    bus.in_valid = 1'b0;
    tick();
    chk("inc_drain", {63'd0, bus.out_valid}, 64'd0);

    // Immediate and shifted immediate
    req(SRC_IMM_SH, FWD_NONE, 64'hFFFF_FFFF_FFFF_FFF8);
    tick();
    chk("imm_sh", bus.out_data, 64'hFFFF_FFFF_FFFF_FFF0);
    req(SRC_IMM, FWD_EXMEM, 64'h8000_0000_0000_0001);
    tick();
    chk("imm", bus.out_data, 64'h8000_0000_0000_0001);
    req(SRC_IMM_SH, FWD_NONE, 64'h8000_0000_0000_0001);
    tick();
    chk("imm_sh_trunc", bus.out_data, 64'h0000_0000_0000_0002);

    // Register source with forwarding, back-to-back
    req(SRC_REG, FWD_NONE, '0);
    tick();
    chk("fwd_none", bus.out_data, 64'd5);
    req(SRC_REG, FWD_EXMEM, '0);
    tick();
    chk("fwd_exmem", bus.out_data, 64'd7);
    req(SRC_REG, FWD_MEMWB, '0);
    tick();
    chk("fwd_memwb", bus.out_data, 64'd9);
    req(SRC_REG, FWD_RSVD, '0);
    tick();
    chk("fwd_rsvd", bus.out_data, 64'd5);
    bus.in_valid = 1'b0;
    tick();

    // Backpressure: fill M and S, then drain in order
    bus.out_ready = 1'b0;
    req(SRC_IMM, FWD_NONE, 64'hA);
    tick();
    chk("bp_ready_one", {63'd0, bus.in_ready}, 64'd1);
    req(SRC_IMM, FWD_NONE, 64'hB);
    tick();
    chk("bp_ready_full", {63'd0, bus.in_ready}, 64'd0);
    chk("bp_head", bus.out_data, 64'hA);
    req(SRC_IMM, FWD_NONE, 64'hC);
    bus.reg_b = 64'd99;
    tick();
    chk("bp_hold", bus.out_data, 64'hA);
    chk("bp_hold_v", {63'd0, bus.out_valid}, 64'd1);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("bp_second", bus.out_data, 64'hB);
    chk("bp_ready_back", {63'd0, bus.in_ready}, 64'd1);
    tick();
    chk("bp_empty", {63'd0, bus.out_valid}, 64'd0);
    bus.reg_b = 64'd5;

    // Flush while FULL with a same-cycle request
    bus.out_ready = 1'b0;
    req(SRC_IMM, FWD_NONE, 64'h11);
    tick();
    req(SRC_IMM, FWD_NONE, 64'h22);
    tick();
    chk("fl_full", {63'd0, bus.in_ready}, 64'd0);
    // in_ready=0 here, so raise out_ready to also offer a transfer during flush
    req(SRC_IMM, FWD_NONE, 64'h33);
    bus.out_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("fl_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("fl_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("fl_data_held", bus.out_data, 64'h11);
    tick();
    chk("fl_stay_empty", {63'd0, bus.out_valid}, 64'd0);
    req(SRC_IMM, FWD_NONE, 64'h44);
    tick();
    chk("fl_after", bus.out_data, 64'h44);
    bus.in_valid = 1'b0;
    tick();

    // Asynchronous reset in FULL
    bus.out_ready = 1'b0;
    req(SRC_IMM, FWD_NONE, 64'h55);
    tick();
    req(SRC_IMM, FWD_NONE, 64'h66);
    tick();
    bus.in_valid = 1'b0;
    chk("ar_full", {63'd0, bus.in_ready}, 64'd0);
    #1 reset = 1'b1;
    #1;
    chk("ar_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("ar_data",  bus.out_data, 64'd0);
    chk("ar_ready", {63'd0, bus.in_ready}, 64'd1);
    tick();
    reset = 1'b0;
    bus.out_ready = 1'b1;
    req(SRC_IMM, FWD_NONE, 64'h77);
    tick();
    chk("ar_after", bus.out_data, 64'h77);
    bus.in_valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
